// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian program into instruction memory, then releases cpu_rst.
// Latency: each word is written the cycle after its 4th byte; byte_ready is asserted only in LEN/DATA.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_FINISH,
        S_DONE,
        S_ERROR
    } state_t;

    // One extra bit so a full-memory load (N == 2**ADDR_W) can be counted.
    localparam int          CNT_W     = ADDR_W + 1;
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [23:0]         asm_q, asm_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;

    logic                xfer;
    logic                last_byte;
    logic [31:0]         word;
    logic [CNT_W-1:0]    word_cnt_inc;

    assign byte_ready   = (state_q == S_LEN) || (state_q == S_DATA);
    assign busy         = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_FINISH);
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERROR);
    assign cpu_rst      = (state_q != S_DONE);
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;

    assign xfer         = byte_valid && byte_ready;
    assign last_byte    = xfer && (byte_cnt_q == 2'd3);
    // Earlier bytes shift down so byte k lands in bits [8k+7:8k] when the 4th arrives.
    assign word         = {byte_data, asm_q};
    assign word_cnt_inc = word_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            asm_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            asm_q      <= asm_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        asm_d      = asm_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (xfer) begin
            asm_d      = {byte_data, asm_q[23:8]};
            byte_cnt_d = byte_cnt_q + 2'd1;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_LEN;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    asm_d      = '0;
                end
            end
            S_LEN: begin
                if (last_byte) begin
                    if (word == 32'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, word} > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d    = S_DATA;
                        len_d      = word[CNT_W-1:0];
                        word_cnt_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (last_byte) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = word_cnt_q[ADDR_W-1:0];
                    wr_data_d  = word;
                    word_cnt_d = word_cnt_inc;
                    if (word_cnt_inc == len_q) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, default 10, word-address width of the instruction memory write port; capacity 2**ADDR_W words.
REQ-002 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-003 Port: clk  in  1  clock; all state changes on its rising edge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: start  in  1  single-cycle request to begin a program load.
REQ-006 Port: byte_valid  in  1  byte_data holds a valid byte.
REQ-007 Port: byte_data  in  8  incoming program byte.
REQ-008 Port: byte_ready  out  1  loader accepts a byte this cycle; transfer = byte_valid && byte_ready.
REQ-009 Port: wr_en  out  1  instruction memory write strobe, one cycle per word.
REQ-010 Port: wr_addr  out  ADDR_W  word address of the write.
REQ-011 Port: wr_data  out  32  instruction word to write.
REQ-012 Port: cpu_rst  out  1  holds the pipeline in reset while high.
REQ-013 Port: busy  out  1  load in progress (LEN, DATA or FINISH).
REQ-014 Port: done  out  1  last load completed successfully.
REQ-015 Port: error  out  1  last load rejected (length overflow).

Function
REQ-016 States SHALL be IDLE, LEN, DATA, FINISH, DONE, ERROR; all outputs are registered or decoded from state only.
REQ-017 Stream format SHALL be: 4-byte little-endian word count N, then N words, each 4 bytes little-endian.
REQ-018 Byte k (0..3) of a group SHALL occupy bits [8k+7:8k] of the assembled word; a 2-bit byte counter wraps 3->0.
REQ-019 byte_ready SHALL be 1 in LEN and DATA only; bytes with byte_valid=1 in other states are not consumed.
REQ-020 start in IDLE, DONE or ERROR SHALL enter LEN next cycle, clearing byte counter, word counter, done and error; start in LEN, DATA or FINISH is ignored.
REQ-021 On the 4th LEN byte: N==0 -> DONE; N > 2**ADDR_W -> ERROR; otherwise -> DATA.
REQ-022 On the 4th byte of word i in DATA, the cycle after SHALL present wr_en=1, wr_addr=i, wr_data=assembled word, for exactly one cycle.
REQ-023 Word counter SHALL increment on each write; wr_addr for word i equals i modulo 2**ADDR_W (no wrap reachable given REQ-021).
REQ-024 When word N-1 completes, state SHALL go to FINISH (the cycle carrying the final wr_en), then to DONE next cycle.
REQ-025 A byte may be accepted every cycle; a write cycle for word i SHALL coincide with accepting byte 0 of word i+1 without loss.
REQ-026 cpu_rst SHALL be 1 in IDLE, LEN, DATA, FINISH, ERROR and 0 only in DONE, so the pipeline leaves reset the cycle after the final write.
REQ-027 done SHALL be 1 only in DONE; error SHALL be 1 only in ERROR; busy SHALL be 1 in LEN, DATA, FINISH.
REQ-028 Gaps in byte_valid SHALL stall assembly indefinitely with no timeout; partial state is retained.
REQ-029 wr_en SHALL be 0 in every cycle not named in REQ-022/REQ-024.

Reset
REQ-030 rst SHALL force IDLE, byte/word counters 0, wr_en=0, wr_addr=0, wr_data=0, byte_ready=0, busy=0, done=0, error=0, cpu_rst=1.
REQ-031 rst SHALL take priority over start and byte transfers in the same cycle.
REQ-032 rst mid-load SHALL abort; words already written stay in memory; no further wr_en until a new start.

Verification
REQ-033 start, bytes 02 00 00 00, 13 00 00 00, 73 00 10 00 back-to-back -> wr_en at addr 0 data 0x00000013, then addr 1 data 0x00100073; done=1, cpu_rst=0 the cycle after the second write.
REQ-034 start, length 00 00 00 00 -> no wr_en, DONE entered the cycle after the 4th byte, cpu_rst=0.
REQ-035 ADDR_W=10, length 01 04 00 00 (N=1025) -> ERROR, error=1, cpu_rst=1, byte_ready=0, no wr_en; later start returns to LEN with error=0.
REQ-036 N=1 with byte_valid toggling 1/0 every cycle -> single write addr 0 data matching bytes; state stable during gaps.
REQ-037 rst asserted after 2 of 3 words written -> IDLE, cpu_rst=1, no third write; fresh start reloads from addr 0.
REQ-038 start pulsed during DATA -> ignored; load completes with correct addresses and count.
